kl8e_tx: RTL
============

KL8E_TX -- requirements
Module: kl8e_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate; bit time DIV = CLOCK_FREQ/BAUD clocks (integer, DIV >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port instruction  input  [0:11]  current instruction (bit 0 MSB).
REQ-006 SHALL have port state  input  [4:0]  CPU major state; IOTs act only in F1.
REQ-007 SHALL have port clear  input  1  synchronous clear, same effect as reset.
REQ-008 SHALL have port UF  input  1  user-mode flag; when 1 all IOTs are ignored.
REQ-009 SHALL have port ac  input  [0:11]  accumulator; character is ac[4:11].
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port flag  output  1  printer (transmit-done) flag.
REQ-012 SHALL have port interrupt  output  1  registered interrupt request.
REQ-013 SHALL have port skip  output  1  registered skip request.

Function
REQ-014 SHALL clear skip on every F1 cycle with UF=0, then set it per REQ-016/REQ-019 in that same cycle.
REQ-015 SHALL decode IOTs only when state==F1 and UF==0; one action per instruction.
REQ-016 SHALL implement: 6040 SPF flag<=1; 6041 TSF skip<=flag; 6042 TCF flag<=0; 6044 TPC load ac[4:11] and start; 6046 TLS flag<=0, load ac[4:11] and start.
REQ-017 SHALL implement 6035 KIE: int_ena<=ac[11].
REQ-018 SHALL implement 6007 CAF: flag<=0, int_ena<=1, abort any frame, clear pending, tx<=1 next clock.
REQ-019 SHALL implement 6045 SPI: skip<=(flag & int_ena).
REQ-020 SHALL drive interrupt <= flag & int_ena each clock (one-clock latency).
REQ-021 SHALL run FSM IDLE -> START -> DATA -> STOP -> IDLE; each bit exactly DIV clocks.
REQ-022 SHALL, on load in IDLE, enter START on the next clock with tx=0.
REQ-023 SHALL send 8 data bits LSB first (ac[11] first) in DATA, then 1 stop bit (tx=1).
REQ-024 SHALL, at end of STOP, set flag=1 and go to IDLE, or go to START directly if a character is pending.
REQ-025 SHALL, on load while not IDLE, store the character in a one-deep pending buffer; a second load overwrites it; the active frame is not disturbed.
REQ-026 SHALL give IOT flag clear (TCF/TLS) priority over end-of-frame flag set in the same cycle.
REQ-027 SHALL ignore IOTs 604x/6035 with UF=1; the transmitter keeps running.

Reset
REQ-028 SHALL, on reset or clear: tx=1, flag=0, int_ena=1, skip=0, interrupt=0, FSM=IDLE, pending empty, bit counter and divider zeroed.
REQ-029 SHALL abort a frame in progress on reset; tx returns high on the next clock.

Configuration
REQ-030 SHALL support macro KL8E_TX_PARITY_EN: defined -> the 8th data bit is even parity over ac[5:11] instead of ac[4]; undefined -> ac[4] is sent unmodified.

Verification (CLOCK_FREQ=1000, BAUD=100, DIV=10)
REQ-031 SHALL check TLS with ac=12'o0101: tx low 10 clocks, bits 1,0,0,0,0,0,1,0 each 10 clocks, stop 10 clocks; flag=1 after 100 clocks.
REQ-032 SHALL check flag=1, KIE ac[11]=1: interrupt=1 one clock later; TSF -> skip=1; TCF -> flag=0, interrupt=0 next clock.
REQ-033 SHALL check TPC 12'o0101 then TPC 12'o0102 at clock 20: both frames back to back, no idle gap, flag set only after second frame.
REQ-034 SHALL check CAF at clock 35 of a frame: tx=1 next clock, flag=0, int_ena=1, no further transitions.
REQ-035 SHALL check TCF coincident with end-of-stop: flag remains 0.
REQ-036 SHALL check with KL8E_TX_PARITY_EN, ac=12'o0001: 8th data bit 1; ac=12'o0003: 8th data bit 0.

Source files
------------

// File: rtl/kl8e_tx.sv
// KL8E-style teleprinter transmitter: PDP-8 IOT decode plus an 8N1 UART frame engine.
// Optional macro KL8E_TX_PARITY_EN replaces the 8th data bit with even parity over ac[5:11].
module kl8e_tx #(
   parameter int         CLOCK_FREQ = 50000000,
   parameter int         BAUD       = 9600,
   parameter logic [4:0] F1_STATE   = 5'b00001   // encoding of the CPU F1 major state
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:11] instruction,
   input  logic [4:0]  state,
   input  logic        clear,
   input  logic        UF,
   input  logic [0:11] ac,
   output logic        tx,
   output logic        flag,
   output logic        interrupt,
   output logic        skip
);

   localparam int DIV   = CLOCK_FREQ / BAUD;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   tx_state_t        cur;
   tx_state_t        nxt;
   logic [CNT_W-1:0] div_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [7:0]       pend;
   logic             pend_vld;
   logic             int_ena;
   logic             tx_next;

   logic             iot_en;
   logic             spf, tsf, tcf, tpc, tls, kie, caf, spi;
   logic             load;
   logic             bit_end;
   logic             frame_done;
   logic             go_start_eof;
   logic             eof_set;
   logic             enter_start;
   logic [7:0]       char_new;
   logic [7:0]       frame_char;
   logic             unused_ac;

   assign unused_ac = ^ac[0:3];

   assign iot_en = (state == F1_STATE) && !UF;
   assign spf    = iot_en && (instruction == 12'o6040);
   assign tsf    = iot_en && (instruction == 12'o6041);
   assign tcf    = iot_en && (instruction == 12'o6042);
   assign tpc    = iot_en && (instruction == 12'o6044);
   assign spi    = iot_en && (instruction == 12'o6045);
   assign tls    = iot_en && (instruction == 12'o6046);
   assign kie    = iot_en && (instruction == 12'o6035);
   assign caf    = iot_en && (instruction == 12'o6007);
   assign load   = tpc || tls;

`ifdef KL8E_TX_PARITY_EN
   assign char_new = {^ac[5:11], ac[5:11]};
`else
   assign char_new = ac[4:11];
`endif

   assign bit_end      = (div_cnt == CNT_W'(DIV - 1));
   assign frame_done   = (cur == STOP) && bit_end;
   // A load arriving in the very cycle the stop bit ends chains straight into the next frame.
   assign go_start_eof = frame_done && (pend_vld || load) && !caf;
   assign eof_set      = frame_done && !(pend_vld || load) && !caf;
   assign enter_start  = (nxt == START) && (cur != START);
   assign frame_char   = load ? char_new : pend;

   // State register plus all architectural registers.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cur       <= IDLE;
         tx        <= 1'b1;
         flag      <= 1'b0;
         int_ena   <= 1'b1;
         skip      <= 1'b0;
         interrupt <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         pend      <= '0;
         pend_vld  <= 1'b0;
      end else begin
         cur       <= nxt;
         tx        <= tx_next;
         interrupt <= flag & int_ena;

         // Clearing IOTs win over the end-of-frame set.
         if (tcf || tls || caf)
            flag <= 1'b0;
         else if (spf || eof_set)
            flag <= 1'b1;

         if (caf)
            int_ena <= 1'b1;
         else if (kie)
            int_ena <= ac[11];

         if (iot_en)
            skip <= (tsf & flag) | (spi & flag & int_ena);

         if (caf || (cur == IDLE) || bit_end)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + CNT_W'(1);

         if (caf)
            bit_cnt <= '0;
         else if ((cur == DATA) && bit_end)
            bit_cnt <= bit_cnt + 3'd1;

         if (enter_start)
            shreg <= frame_char;
         else if ((cur == DATA) && bit_end)
            shreg <= {1'b0, shreg[7:1]};

         if (caf)
            pend_vld <= 1'b0;
         else if (load && (cur != IDLE) && !frame_done) begin
            pend     <= char_new;
            pend_vld <= 1'b1;
         end else if (go_start_eof)
            pend_vld <= 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      nxt = cur;
      if (caf) begin
         nxt = IDLE;
      end else begin
         case (cur)
            IDLE:  if (load) nxt = START;
            START: if (bit_end) nxt = DATA;
            DATA:  if (bit_end && (bit_cnt == 3'd7)) nxt = STOP;
            STOP:  if (bit_end) nxt = go_start_eof ? START : IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // Output logic: line level for the state being entered.
   always_comb begin
      tx_next = 1'b1;
      case (nxt)
         START:   tx_next = 1'b0;
         DATA:    tx_next = ((cur == DATA) && bit_end) ? shreg[1] : shreg[0];
         default: tx_next = 1'b1;
      endcase
   end

endmodule
